// File: rtl/wb_openram_arbiter.sv
// Shares one OpenRAM single-port macro between a Wishbone slave and a simple
// request/grant port B. Every access takes a fixed 4 cycles, and contention is resolved round-robin.
module wb_openram_arbiter #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [31:0] wbs_adr_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    input  logic        b_req_i,
    input  logic        b_we_i,
    input  logic [3:0]  b_wmask_i,
    input  logic [7:0]  b_addr_i,
    input  logic [31:0] b_wdata_i,
    output logic        b_gnt_o,
    output logic        b_done_o,
    output logic [31:0] b_rdata_o,
    output logic        ram_clk0,
    output logic        ram_csb0,
    output logic        ram_web0,
    output logic [3:0]  ram_wmask0,
    output logic [7:0]  ram_addr0,
    output logic [31:0] ram_din0,
    input  logic [31:0] ram_dout0
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t      state_q, state_d;
    logic        last_b_q, last_b_d;
    logic        owner_b_q, owner_b_d;
    logic        we_q, we_d;
    logic        csb_q, csb_d;
    logic        web_q, web_d;
    logic [3:0]  wmask_q, wmask_d;
    logic [7:0]  addr_q, addr_d;
    logic [31:0] din_q, din_d;
    logic        ack_q, ack_d;
    logic [31:0] wbs_dat_q, wbs_dat_d;
    logic        b_gnt_q, b_gnt_d;
    logic        b_done_q, b_done_d;
    logic [31:0] b_rdata_q, b_rdata_d;

    logic wb_req;
    logic pick_b;
    logic unused_adr_bits;

    assign ram_clk0        = wb_clk_i;
    assign unused_adr_bits = ^wbs_adr_i[1:0];

    assign wb_req = wbs_stb_i & wbs_cyc_i & (wbs_adr_i[31:10] == BASE_ADDR[31:10]);
    // When both are pending, port B wins only if Wishbone was served last.
    assign pick_b = b_req_i & (~wb_req | ~last_b_q);

    // NOTE: every variable gets a default first, so no path can leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        last_b_d  = last_b_q;
        owner_b_d = owner_b_q;
        we_d      = we_q;
        csb_d     = 1'b1;
        web_d     = 1'b1;
        wmask_d   = 4'b0000;
        addr_d    = addr_q;
        din_d     = din_q;
        ack_d     = 1'b0;
        wbs_dat_d = wbs_dat_q;
        b_gnt_d   = 1'b0;
        b_done_d  = 1'b0;
        b_rdata_d = b_rdata_q;

        case (state_q)
            IDLE: begin
                if (wb_req || b_req_i) begin
                    state_d   = ISSUE;
                    owner_b_d = pick_b;
                    last_b_d  = pick_b;
                    csb_d     = 1'b0;
                    b_gnt_d   = pick_b;
                    if (pick_b) begin
                        we_d    = b_we_i;
                        web_d   = ~b_we_i;
                        wmask_d = b_we_i ? b_wmask_i : 4'b0000;
                        addr_d  = b_addr_i;
                        din_d   = b_wdata_i;
                    end else begin
                        we_d    = wbs_we_i;
                        web_d   = ~wbs_we_i;
                        wmask_d = wbs_we_i ? wbs_sel_i : 4'b0000;
                        addr_d  = wbs_adr_i[9:2];
                        din_d   = wbs_dat_i;
                    end
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                state_d = DONE;
                if (!we_q) begin
                    if (owner_b_q) b_rdata_d = ram_dout0;
                    else           wbs_dat_d = ram_dout0;
                end
                // A master that dropped cyc has abandoned the cycle, so its ack is suppressed.
                ack_d    = ~owner_b_q & wbs_cyc_i;
                b_done_d = owner_b_q;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments, so every flop samples its pre-edge _d value.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q   <= IDLE;
            last_b_q  <= 1'b1;
            owner_b_q <= 1'b0;
            we_q      <= 1'b0;
            csb_q     <= 1'b1;
            web_q     <= 1'b1;
            wmask_q   <= 4'b0000;
            addr_q    <= 8'h00;
            din_q     <= 32'h0;
            ack_q     <= 1'b0;
            wbs_dat_q <= 32'h0;
            b_gnt_q   <= 1'b0;
            b_done_q  <= 1'b0;
            b_rdata_q <= 32'h0;
        end else begin
            state_q   <= state_d;
            last_b_q  <= last_b_d;
            owner_b_q <= owner_b_d;
            we_q      <= we_d;
            csb_q     <= csb_d;
            web_q     <= web_d;
            wmask_q   <= wmask_d;
            addr_q    <= addr_d;
            din_q     <= din_d;
            ack_q     <= ack_d;
            wbs_dat_q <= wbs_dat_d;
            b_gnt_q   <= b_gnt_d;
            b_done_q  <= b_done_d;
            b_rdata_q <= b_rdata_d;
        end
    end

    assign ram_csb0   = csb_q;
    assign ram_web0   = web_q;
    assign ram_wmask0 = wmask_q;
    assign ram_addr0  = addr_q;
    assign ram_din0   = din_q;
    assign wbs_ack_o  = ack_q;
    assign wbs_dat_o  = wbs_dat_q;
    assign b_gnt_o    = b_gnt_q;
    assign b_done_o   = b_done_q;
    assign b_rdata_o  = b_rdata_q;

endmodule
